mmio_sig_ctrl: RTL
==================

// Module: mmio_sig_ctrl
// PURPOSE
//  Synthesizable sequencer for the tiny-SoC MMIO signalling port. Decodes core writes to the
//  stop/trap/int-dump/float-dump addresses, buffers dump records in a FIFO and streams them to a host.
//  Sequences the end-of-run: RUN -> DRAIN (countdown) -> DONE, or DONE directly on a cycle limit.
//  Sits between top_tiny_soc mmio_*_o and the host/FPGA harness.
// PARAMETERS
//  ADDR_STOP      31'h6000_0000  stop-signal address
//  ADDR_TRAP      31'h6000_0008  trap-signal address
//  ADDR_REG_DUMP  31'h6000_0010  integer register dump address
//  ADDR_FREG_DUMP 31'h6000_0018  float register dump address
//  DRAIN_CYCLES   500            cycles run after stop/trap before DONE
//  FIFO_DEPTH     4              record FIFO entries (power of 2, >=2)
// PORTS
//  clk_i         in   1   clock
//  rst_ni        in   1   async active-low reset
//  mmio_req_i    in   1   MMIO request from SoC
//  mmio_we_i     in   1   write enable
//  mmio_addr_i   in   31  byte address
//  mmio_wdata_i  in   64  write data
//  mmio_strb_i   in   8   byte strobes (ignored for decode, recorded nowhere)
//  mmio_gnt_o    out  1   access accepted this cycle
//  simlen_i      in   32  cycle limit; 0 = disabled; quasi-static
//  rec_valid_o   out  1   record available
//  rec_ready_i   in   1   host accepts record
//  rec_kind_o    out  2   0 STOP, 1 TRAP, 2 IREG, 3 FREG
//  rec_idx_o     out  6   register index (dumps), 0 otherwise
//  rec_data_o    out  64  wdata of the access
//  done_o        out  1   run finished (sticky)
//  stop_cause_o  out  2   0 none, 1 stop, 2 trap, 3 simlen
//  cycle_cnt_o   out  32  cycles since reset release
// BEHAVIOUR
//  - Reset: state RUN, FIFO empty, rec_valid_o=0, done_o=0, stop_cause_o=0, cycle_cnt_o=0,
//    int index=1, float index=0, drain count=0. Async reset mid-operation discards all state/records.
//  - mmio_gnt_o (comb from regs): RUN: !fifo_full; DRAIN/DONE: 1 (accepted, discarded).
//  - Hit = req & we & gnt & addr==ADDR_x (exact compare). Reads (we=0) granted per same rule, no effect.
//  - RUN hits push one record {kind, idx, wdata}; pushed record visible on rec_valid_o next cycle.
//    IREG: idx=int index, then index++ (mod 64). FREG: idx=float index, then ++ (mod 64).
//  - STOP hit in RUN: push STOP record, cause=1, load drain=DRAIN_CYCLES, -> DRAIN.
//  - TRAP hit in RUN: push TRAP record; stop behaviour per CONFIGURATION (cause=2).
//  - DRAIN: each cycle if drain==0 -> DONE else drain--. DONE reached DRAIN_CYCLES+1 edges after hit.
//  - cycle_cnt increments every cycle in RUN/DRAIN, frozen in DONE, saturates at 2^32-1.
//  - simlen_i!=0 and cycle_cnt==simlen_i-1 in RUN/DRAIN: -> DONE, cause=3 (overrides stop/trap same cycle).
//  - DONE sticky until reset; done_o = (state==DONE), registered.
//  - FIFO: valid/ready; pop when rec_valid_o & rec_ready_i; push+pop same cycle when full allowed
//    only via gnt (gnt low when full, no push). FIFO keeps draining to host in DRAIN/DONE.
//  - Records never dropped: SoC stalls on full FIFO.
// CONFIGURATION
//  MMIO_SIG_DONTSTOP_ON_TRAP_EN defined: TRAP hit pushes record only; state stays RUN, cause unchanged.
//  Not defined: TRAP hit behaves as STOP (drain countdown) with stop_cause_o=2.
// TESTING
//  - Reset, 3 IREG writes 0x11,0x22,0x33, ready=1 -> records IREG idx 1,2,3 data as written.
//  - 2 FREG writes then 1 IREG -> FREG idx 0,1; IREG idx 1; indices independent.
//  - STOP at cycle 20, DRAIN_CYCLES=500 -> done_o rises 501 edges later, cause=1; later IREG writes
//    granted, no records.
//  - ready=0, 5 IREG writes, depth 4 -> gnt low on 5th until one pop; all 5 records in order.
//  - simlen_i=100, no stop -> done_o set after cycle_cnt==99, cause=3, cycle_cnt frozen at 100.
//  - TRAP at cycle 10 -> without macro DONE after 501 edges cause=2; with macro stays RUN, cause=0.

Source files
------------

// File: rtl/mmio_sig_ctrl.sv
// ---------------------------------------------------------------------------
// mmio_sig_ctrl
//   End-of-run sequencer for the tiny-SoC MMIO signalling port. Decodes core
//   writes to the stop / trap / integer-dump / float-dump addresses, buffers
//   the resulting records in a small FIFO that streams to the host, and walks
//   RUN -> DRAIN (countdown) -> DONE, or jumps to DONE on the cycle limit.
//
//   Optional feature macro: MMIO_SIG_DONTSTOP_ON_TRAP_EN
//     defined     : a TRAP write only pushes its record, the run continues.
//     not defined : a TRAP write ends the run like STOP, with cause = trap.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   mmio_req_i/we_i          MMIO request and write enable from the SoC
//   mmio_addr_i[30:0]        byte address (exact match decode)
//   mmio_wdata_i[63:0]       write data, copied into records
//   mmio_strb_i[7:0]         byte strobes, not used
//   mmio_gnt_o               access accepted this cycle
//   simlen_i[31:0]           cycle limit, 0 disables, quasi-static
//   rec_valid_o/rec_ready_i  record stream handshake towards the host
//   rec_kind_o[1:0]          0 STOP, 1 TRAP, 2 IREG, 3 FREG
//   rec_idx_o[5:0]           register index for dump records, else 0
//   rec_data_o[63:0]         write data of the recorded access
//   done_o                   run finished (sticky until reset)
//   stop_cause_o[1:0]        0 none, 1 stop, 2 trap, 3 cycle limit
//   cycle_cnt_o[31:0]        cycles spent in RUN/DRAIN since reset release
// ---------------------------------------------------------------------------
module mmio_sig_ctrl #(
    parameter logic [30:0] ADDR_STOP      = 31'h6000_0000,
    parameter logic [30:0] ADDR_TRAP      = 31'h6000_0008,
    parameter logic [30:0] ADDR_REG_DUMP  = 31'h6000_0010,
    parameter logic [30:0] ADDR_FREG_DUMP = 31'h6000_0018,
    parameter int unsigned DRAIN_CYCLES   = 500,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mmio_req_i,
    input  logic        mmio_we_i,
    input  logic [30:0] mmio_addr_i,
    input  logic [63:0] mmio_wdata_i,
    input  logic [7:0]  mmio_strb_i,
    output logic        mmio_gnt_o,
    input  logic [31:0] simlen_i,
    output logic        rec_valid_o,
    input  logic        rec_ready_i,
    output logic [1:0]  rec_kind_o,
    output logic [5:0]  rec_idx_o,
    output logic [63:0] rec_data_o,
    output logic        done_o,
    output logic [1:0]  stop_cause_o,
    output logic [31:0] cycle_cnt_o
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [PTR_W:0]     PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};

    localparam logic [1:0] KIND_STOP = 2'd0;
    localparam logic [1:0] KIND_TRAP = 2'd1;
    localparam logic [1:0] KIND_IREG = 2'd2;
    localparam logic [1:0] KIND_FREG = 2'd3;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_STOP   = 2'd1;
    localparam logic [1:0] CAUSE_TRAP   = 2'd2;
    localparam logic [1:0] CAUSE_SIMLEN = 2'd3;

`ifdef MMIO_SIG_DONTSTOP_ON_TRAP_EN
    localparam logic TRAP_STOPS = 1'b0;
`else
    localparam logic TRAP_STOPS = 1'b1;
`endif

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0]  kind;
        logic [5:0]  idx;
        logic [63:0] data;
    } rec_t;

    state_e               state_q;
    logic                 done_q;
    logic [1:0]           cause_q;
    logic [31:0]          cycle_cnt_q;
    logic [31:0]          cycle_cnt_d;
    logic [DRAIN_W-1:0]   drain_q;
    logic [5:0]           int_idx_q;
    logic [5:0]           flt_idx_q;

    rec_t                 fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q;
    logic [PTR_W:0]       wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q;
    logic [PTR_W:0]       rd_ptr_d;

    logic                 fifo_empty_s;
    logic                 fifo_full_s;
    logic                 gnt_s;
    logic                 wr_acc_s;
    logic                 hit_stop_s;
    logic                 hit_trap_s;
    logic                 hit_ireg_s;
    logic                 hit_freg_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 limit_hit_s;
    logic [1:0]           push_kind_s;
    logic [5:0]           push_idx_s;
    logic                 strb_unused_s;

    assign strb_unused_s = ^mmio_strb_i;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                          (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // Grant: RUN stalls the SoC on a full FIFO; after the run ends every access is swallowed.
    always_comb begin
        gnt_s = 1'b1;
        if (state_q == ST_RUN) begin
            gnt_s = !fifo_full_s;
        end else begin
            gnt_s = 1'b1;
        end
    end

    assign wr_acc_s   = mmio_req_i & mmio_we_i & gnt_s;
    assign hit_stop_s = wr_acc_s && (mmio_addr_i == ADDR_STOP);
    assign hit_trap_s = wr_acc_s && (mmio_addr_i == ADDR_TRAP);
    assign hit_ireg_s = wr_acc_s && (mmio_addr_i == ADDR_REG_DUMP);
    assign hit_freg_s = wr_acc_s && (mmio_addr_i == ADDR_FREG_DUMP);

    // Only RUN records accesses; DRAIN/DONE hits are granted and dropped.
    assign push_s = (state_q == ST_RUN) & (hit_stop_s | hit_trap_s | hit_ireg_s | hit_freg_s);
    assign pop_s  = !fifo_empty_s & rec_ready_i;

    // Cycle limit compares against the pre-increment count, so DONE lands with count == simlen.
    assign limit_hit_s = (simlen_i != 32'd0) && (cycle_cnt_q == (simlen_i - 32'd1)) &&
                         (state_q != ST_DONE);

    // Kind and index of the record formed by this cycle's hit.
    always_comb begin
        push_kind_s = KIND_STOP;
        push_idx_s  = 6'd0;
        if (hit_trap_s) begin
            push_kind_s = KIND_TRAP;
            push_idx_s  = 6'd0;
        end else if (hit_ireg_s) begin
            push_kind_s = KIND_IREG;
            push_idx_s  = int_idx_q;
        end else if (hit_freg_s) begin
            push_kind_s = KIND_FREG;
            push_idx_s  = flt_idx_q;
        end else begin
            push_kind_s = KIND_STOP;
            push_idx_s  = 6'd0;
        end
    end

    // Next FIFO pointers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Saturating cycle counter, frozen once the run is DONE.
    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        if ((state_q != ST_DONE) && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end else begin
            cycle_cnt_d = cycle_cnt_q;
        end
    end

    // Record FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_s) begin
                fifo_q[wr_ptr_q[PTR_W-1:0]] <= {push_kind_s, push_idx_s, mmio_wdata_i};
            end
        end
    end

    // Run sequencer: state, cause, drain countdown, dump indices and cycle count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_RUN;
            done_q      <= 1'b0;
            cause_q     <= CAUSE_NONE;
            drain_q     <= '0;
            cycle_cnt_q <= 32'd0;
            int_idx_q   <= 6'd1;
            flt_idx_q   <= 6'd0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            if (push_s && hit_ireg_s) begin
                int_idx_q <= int_idx_q + 6'd1;
            end
            if (push_s && hit_freg_s) begin
                flt_idx_q <= flt_idx_q + 6'd1;
            end
            case (state_q)
                ST_RUN: begin
                    if (limit_hit_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        cause_q <= CAUSE_SIMLEN;
                    end else if (hit_stop_s) begin
                        state_q <= ST_DRAIN;
                        cause_q <= CAUSE_STOP;
                        drain_q <= DRAIN_LOAD;
                    end else if (hit_trap_s && TRAP_STOPS) begin
                        state_q <= ST_DRAIN;
                        cause_q <= CAUSE_TRAP;
                        drain_q <= DRAIN_LOAD;
                    end
                end
                ST_DRAIN: begin
                    if (limit_hit_s) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        cause_q <= CAUSE_SIMLEN;
                    end else if (drain_q == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - DRAIN_ONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
            endcase
        end
    end

    assign mmio_gnt_o   = gnt_s;
    assign rec_valid_o  = !fifo_empty_s;
    assign rec_kind_o   = fifo_q[rd_ptr_q[PTR_W-1:0]].kind;
    assign rec_idx_o    = fifo_q[rd_ptr_q[PTR_W-1:0]].idx;
    assign rec_data_o   = fifo_q[rd_ptr_q[PTR_W-1:0]].data;
    assign done_o       = done_q;
    assign stop_cause_o = cause_q;
    assign cycle_cnt_o  = cycle_cnt_q;

endmodule
